mem_stage_ctrl: RTL

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_ctrl_pkg.sv | 15 +
 rtl/mem_wait_counter.sv | 37 +++
 rtl/mem_stage_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage data-memory handshake controller.
package mem_ctrl_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 15;
  localparam int unsigned WAIT_CNT_W         = 8;
  localparam int unsigned XLEN               = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Counts WAIT cycles without ack; flags the cycle whose increment reaches LIMIT.
module mem_wait_counter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic limit_hit_c
);

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Hit on the WAIT cycle that would bring the count up to LIMIT.
  assign limit_hit_c = en && (cnt_q == WAIT_CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues one data-memory request per load/store and stalls
// the pipeline until ack, with a timeout that aborts into a one-cycle bubble.
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_wrenable,
  input  logic        mem_to_reg,
  input  logic [31:0] alu_res,
  input  logic [31:0] write_data,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        stall,
  output logic        bubble,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        timeout_err,
  output logic [31:0] stall_cycles
);

  state_e            state_q, state_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [XLEN-1:0]   dmem_addr_q, dmem_addr_d;
  logic [XLEN-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic [XLEN-1:0]   load_data_q, load_data_d;
  logic              timeout_err_q, timeout_err_d;
  logic [XLEN-1:0]   stall_cycles_q, stall_cycles_d;

  logic access_c;
  logic cnt_clr_c;
  logic cnt_en_c;
  logic limit_hit_c;
  logic stall_c;
  logic bubble_c;
  logic load_valid_c;

  assign access_c  = mem_valid && (mem_wrenable || mem_to_reg);
  assign cnt_clr_c = (state_q == ST_IDLE) && access_c;
  assign cnt_en_c  = (state_q == ST_WAIT) && !dmem_ack;

  mem_wait_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (cnt_clr_c),
    .en          (cnt_en_c),
    .limit_hit_c (limit_hit_c)
  );

  always_comb begin
    state_d        = state_q;
    dmem_we_d      = dmem_we_q;
    dmem_addr_d    = dmem_addr_q;
    dmem_wdata_d   = dmem_wdata_q;
    load_data_d    = load_data_q;
    timeout_err_d  = timeout_err_q;
    stall_c        = 1'b0;
    bubble_c       = 1'b0;
    load_valid_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (access_c) begin
          state_d      = ST_WAIT;
          stall_c      = 1'b1;
          dmem_we_d    = mem_wrenable;
          dmem_addr_d  = alu_res;
          dmem_wdata_d = write_data;
        end
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        // Ack beats a simultaneous timeout.
        if (dmem_ack) begin
          state_d = ST_DONE;
          if (!dmem_we_q) begin
            load_data_d = dmem_rdata;
          end
        end else if (limit_hit_c) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: begin
        load_valid_c = !dmem_we_q;
        state_d      = ST_IDLE;
      end
      ST_ERR: begin
        bubble_c      = 1'b1;
        timeout_err_d = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    dmem_req_d = (state_d == ST_WAIT);

    if (!rst_n) begin
      stall_c      = 1'b0;
      bubble_c     = 1'b0;
      load_valid_c = 1'b0;
    end

    stall_cycles_d = stall_cycles_q;
    if (stall_c && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      dmem_addr_q    <= '0;
      dmem_wdata_q   <= '0;
      load_data_q    <= '0;
      timeout_err_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      dmem_req_q     <= dmem_req_d;
      dmem_we_q      <= dmem_we_d;
      dmem_addr_q    <= dmem_addr_d;
      dmem_wdata_q   <= dmem_wdata_d;
      load_data_q    <= load_data_d;
      timeout_err_q  <= timeout_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign load_data    = load_data_q;
  assign timeout_err  = timeout_err_q;
  assign stall_cycles = stall_cycles_q;
  assign stall        = stall_c;
  assign bubble       = bubble_c;
  assign load_valid   = load_valid_c;

endmodule
